// File: rtl/ysyx_23060208_dsram_slave.sv
// ysyx_23060208_dsram_slave: AXI4-Lite-style data SRAM responder behind the
// EXU load/store port. Independent read and write FSMs. Each has a response
// latency that can be programmed.
// Optional build macro: DSRAM_RAND_LAT_EN replaces RD_LAT/WR_LAT with
// latencies drawn from a shared 8-bit LFSR.
module ysyx_23060208_dsram_slave #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]  BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned            DEPTH_WORDS = 4096,
    parameter int unsigned            RD_LAT      = 1,
    parameter int unsigned            WR_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dsram_awaddr,
    input  logic                  dsram_awvalid,
    output logic                  dsram_awready,
    input  logic [DATA_WIDTH-1:0] dsram_wdata,
    input  logic [2:0]            dsram_wstrb,
    input  logic                  dsram_wvalid,
    output logic                  dsram_wready,
    output logic [1:0]            dsram_bresp,
    output logic                  dsram_bvalid,
    input  logic                  dsram_bready,
    input  logic [DATA_WIDTH-1:0] dsram_araddr,
    input  logic                  dsram_arvalid,
    output logic                  dsram_arready,
    output logic [DATA_WIDTH-1:0] dsram_rdata,
    output logic [1:0]            dsram_rresp,
    output logic                  dsram_rvalid,
    input  logic                  dsram_rready
);

    localparam int unsigned           NB        = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Write channel state
    wstate_t               r_wstate, w_wnext;
    logic [DATA_WIDTH-1:0] r_awaddr, r_wdata;
    logic [2:0]            r_wstrb;
    logic [3:0]            r_wcnt;
    logic                  r_berr;
    logic                  w_awready, w_wready, w_bvalid, w_wcommit;

    // Read channel state
    rstate_t               r_rstate, w_rnext;
    logic [DATA_WIDTH-1:0] r_araddr, r_rdata;
    logic [3:0]            r_rcnt;
    logic                  r_rerr;
    logic                  w_arready, w_rvalid, w_rsample;

    logic [3:0]            w_wr_lat, w_rd_lat;

`ifdef DSRAM_RAND_LAT_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR (taps 8,6,5,4) shared by both channels for latency draws
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= 8'hA5;
        else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_wr_lat = r_lfsr[3:0];
    assign w_rd_lat = r_lfsr[3:0];
`else
    assign w_wr_lat = 4'(WR_LAT);
    assign w_rd_lat = 4'(RD_LAT);
`endif

    // ---------------- write datapath ----------------
    // With zero latency the commit happens on the W handshake edge itself, so
    // data/size come straight from the bus; otherwise from the latched copy.
    logic [DATA_WIDTH-1:0] w_wr_data, w_wr_shift, w_wr_off;
    logic [2:0]            w_wr_strb;
    logic [1:0]            w_wr_lane;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [NB-1:0]         w_wr_be;
    logic                  w_wr_fmt_ok, w_wr_ok;

    assign w_wr_data  = (r_wstate == W_DATA) ? dsram_wdata : r_wdata;
    assign w_wr_strb  = (r_wstate == W_DATA) ? dsram_wstrb : r_wstrb;
    assign w_wr_lane  = r_awaddr[1:0];
    assign w_wr_off   = r_awaddr - BASE_ADDR;
    assign w_wr_idx   = w_wr_off[IDX_W+1:2];
    assign w_wr_shift = w_wr_data << {w_wr_lane, 3'b000};
    assign w_wr_ok    = (r_awaddr >= BASE_ADDR) && (w_wr_off < MEM_BYTES) && w_wr_fmt_ok;

    // Decode store size into byte enables and check size/alignment legality
    always_comb begin
        w_wr_be     = '0;
        w_wr_fmt_ok = 1'b0;
        case (w_wr_strb)
            3'b100: begin
                w_wr_be     = '1;
                w_wr_fmt_ok = (w_wr_lane == 2'b00);
            end
            3'b010: begin
                w_wr_be     = NB'(3) << w_wr_lane;
                w_wr_fmt_ok = !w_wr_lane[0];
            end
            3'b001: begin
                w_wr_be     = NB'(1) << w_wr_lane;
                w_wr_fmt_ok = 1'b1;
            end
            default: ;
        endcase
    end

    // Write FSM next-state and channel handshake outputs
    always_comb begin
        w_wnext   = r_wstate;
        w_wcommit = 1'b0;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        if (rst) begin
            w_wnext = W_IDLE;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    w_awready = 1'b1;
                    if (dsram_awvalid) w_wnext = W_DATA;
                end
                W_DATA: begin
                    w_wready = 1'b1;
                    if (dsram_wvalid) begin
                        if (w_wr_lat == 4'd0) begin
                            w_wcommit = 1'b1;
                            w_wnext   = W_RESP;
                        end else begin
                            w_wnext = W_DELAY;
                        end
                    end
                end
                W_DELAY: begin
                    if (r_wcnt == 4'd1) begin
                        w_wcommit = 1'b1;
                        w_wnext   = W_RESP;
                    end
                end
                W_RESP: begin
                    w_bvalid = 1'b1;
                    if (dsram_bready) w_wnext = W_IDLE;
                end
                default: w_wnext = W_IDLE;
            endcase
        end
    end

    // Write FSM state register, request latches and latency countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wcnt   <= '0;
            r_berr   <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            if (w_awready && dsram_awvalid) r_awaddr <= dsram_awaddr;
            if (w_wready && dsram_wvalid) begin
                r_wdata <= dsram_wdata;
                r_wstrb <= dsram_wstrb;
                r_wcnt  <= w_wr_lat;
            end else if (r_wstate == W_DELAY) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_wcommit) r_berr <= !w_wr_ok;
        end
    end

    // Byte-lane memory update on a legal commit; contents are never reset
    always_ff @(posedge clk) begin
        if (w_wcommit && w_wr_ok) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_wr_be[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_shift[8*i +: 8];
            end
        end
    end

    // ---------------- read datapath ----------------
    // Zero latency samples on the AR handshake edge, so use the bus address there.
    logic [DATA_WIDTH-1:0] w_rd_addr, w_rd_off, w_rd_word;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_ok;

    assign w_rd_addr = (r_rstate == R_IDLE) ? dsram_araddr : r_araddr;
    assign w_rd_off  = w_rd_addr - BASE_ADDR;
    assign w_rd_idx  = w_rd_off[IDX_W+1:2];
    assign w_rd_ok   = (w_rd_addr >= BASE_ADDR) && (w_rd_off < MEM_BYTES);
    assign w_rd_word = r_mem[w_rd_idx];

    // Read FSM next-state and channel handshake outputs
    always_comb begin
        w_rnext   = r_rstate;
        w_rsample = 1'b0;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        if (rst) begin
            w_rnext = R_IDLE;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    w_arready = 1'b1;
                    if (dsram_arvalid) begin
                        if (w_rd_lat == 4'd0) begin
                            w_rsample = 1'b1;
                            w_rnext   = R_RESP;
                        end else begin
                            w_rnext = R_DELAY;
                        end
                    end
                end
                R_DELAY: begin
                    if (r_rcnt == 4'd1) begin
                        w_rsample = 1'b1;
                        w_rnext   = R_RESP;
                    end
                end
                R_RESP: begin
                    w_rvalid = 1'b1;
                    if (dsram_rready) w_rnext = R_IDLE;
                end
                default: w_rnext = R_IDLE;
            endcase
        end
    end

    // Read FSM state register, address latch, countdown and response sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_araddr <= '0;
            r_rcnt   <= '0;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (w_arready && dsram_arvalid) begin
                r_araddr <= dsram_araddr;
                r_rcnt   <= w_rd_lat;
            end else if (r_rstate == R_DELAY) begin
                r_rcnt <= r_rcnt - 4'd1;
            end
            if (w_rsample) begin
                r_rerr  <= !w_rd_ok;
                r_rdata <= w_rd_ok ? (w_rd_word >> {w_rd_addr[1:0], 3'b000}) : '0;
            end
        end
    end

    assign dsram_awready = w_awready;
    assign dsram_wready  = w_wready;
    assign dsram_bvalid  = w_bvalid;
    assign dsram_bresp   = w_bvalid ? {r_berr, 1'b0} : 2'b00;
    assign dsram_arready = w_arready;
    assign dsram_rvalid  = w_rvalid;
    assign dsram_rresp   = w_rvalid ? {r_rerr, 1'b0} : 2'b00;
    assign dsram_rdata   = w_rvalid ? r_rdata : '0;

endmodule
